// File: rtl/uart_debug_pkg.sv
// Shared constants and helpers for the multi-channel debug seven-segment display.
// The segment table is active-high with bit order {g,f,e,d,c,b,a}.
package uart_debug_pkg;

  // Entry i holds the pattern for hex digit i. The first element listed is index 15.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble, input logic active_low);
    return active_low ? ~SEG_HEX[nibble] : SEG_HEX[nibble];
  endfunction

  // The selector is at least one bit wide, so a single-channel build still has a sel_o port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_debug_seg_mux_hex7seg_dec.sv
// Combinational decoder from one hex nibble to one seven-segment digit.
module hex7seg_dec
  import uart_debug_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_encode(nibble, ACTIVE_LOW);

endmodule

// File: rtl/uart_debug_seg_mux.sv
// Multi-channel debug display: shadow capture, sticky change flags, manual/auto paging
// and a registered seven-segment output for the selected channel.
module uart_debug_seg_mux
  import uart_debug_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned CYCLE_TICKS    = 50_000_000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  localparam int W  = NUM_DIGITS * 4,
  localparam int SW = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [NUM_CH*W-1:0]     ch_data,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic                    next_i,
  input  logic                    auto_en,
  input  logic                    freeze,
  input  logic                    clr_sticky,
  output logic [NUM_DIGITS*7-1:0] seg_o,
  output logic [SW-1:0]           sel_o,
  output logic [NUM_CH-1:0]       upd_o
);

  localparam int CW = $clog2(CYCLE_TICKS);
  localparam logic [NUM_DIGITS*7-1:0] SEG_RST = {NUM_DIGITS{seg_encode(4'h0, SEG_ACTIVE_LOW)}};

  // ch_valid is a one-cycle capture strobe with no backpressure: a word is taken in the
  // cycle its strobe is high unless freeze is set, in which case it is simply dropped.
  logic [NUM_CH-1:0][W-1:0] shadow;
  logic [NUM_CH-1:0]        cap;
  logic [NUM_CH-1:0]        set_upd;
  logic [NUM_CH-1:0]        clr_upd;
  logic                     next_q;
  logic                     manual_adv;
  logic                     tick_tc;
  logic                     adv;
  logic [CW-1:0]            tick_cnt;
  logic [SW-1:0]            sel_next;
  logic [W-1:0]             cur_word;
  logic [NUM_DIGITS*7-1:0]  seg_dec;

  assign manual_adv = next_i & ~next_q;
  assign tick_tc    = auto_en && (tick_cnt == CW'(CYCLE_TICKS - 1));
  assign adv        = manual_adv | tick_tc;
  assign sel_next   = (sel_o == SW'(NUM_CH - 1)) ? '0 : sel_o + 1'b1;

  always_comb begin
    cap     = '0;
    set_upd = '0;
    clr_upd = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cap[k]     = ch_valid[k] && !freeze;
      set_upd[k] = cap[k] && (ch_data[k*W +: W] != shadow[k]);
      // Only a real change of selection onto k clears it; a one-channel build never moves.
      clr_upd[k] = clr_sticky || (adv && (sel_next != sel_o) && (sel_next == SW'(k)));
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shadow <= '0;
      upd_o  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cap[k]) shadow[k] <= ch_data[k*W +: W];
      end
      upd_o <= set_upd | (upd_o & ~clr_upd);
    end
  end

  // A manual press restarts the full auto period; a press on terminal count is one step.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      next_q   <= 1'b0;
      tick_cnt <= '0;
      sel_o    <= '0;
    end else begin
      next_q <= next_i;
      if (!auto_en || manual_adv || tick_tc) tick_cnt <= '0;
      else                                   tick_cnt <= tick_cnt + 1'b1;
      if (adv) sel_o <= sel_next;
    end
  end

  assign cur_word = shadow[sel_o];

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    hex7seg_dec #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
      .nibble (cur_word[d*4 +: 4]),
      .seg    (seg_dec[d*7 +: 7])
    );
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) seg_o <= SEG_RST;
    else         seg_o <= seg_dec;
  end

endmodule
